// File: rtl/multi_digit_seconds_counter.sv
// Prescaled BCD up/down seconds counter, DIGITS wide, multiplexed onto one 7-segment bus.
// Optional build macro: LEADING_ZERO_BLANK_EN (blank leading zeros, digit0 always shown).

module seg7 (
    input  logic [3:0] bcd,
    output logic [6:0] seg
);
    always_comb begin
        seg = 7'h00;
        case (bcd)
            4'd0: seg = 7'h3F;
            4'd1: seg = 7'h06;
            4'd2: seg = 7'h5B;
            4'd3: seg = 7'h4F;
            4'd4: seg = 7'h66;
            4'd5: seg = 7'h6D;
            4'd6: seg = 7'h7D;
            4'd7: seg = 7'h07;
            4'd8: seg = 7'h7F;
            4'd9: seg = 7'h6F;
            default: seg = 7'h00;
        endcase
    end
endmodule

// One BCD digit; cin steps it, cout is the carry/borrow into the next digit.
module msc_digit (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       cin,
    input  logic       up,
    output logic [3:0] value,
    output logic       cout
);
    assign cout = cin && (up ? (value == 4'd9) : (value == 4'd0));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value <= 4'd0;
        end else if (clear) begin
            value <= 4'd0;
        end else if (cin) begin
            if (up) value <= (value == 4'd9) ? 4'd0 : value + 4'd1;
            else    value <= (value == 4'd0) ? 4'd9 : value - 4'd1;
        end
    end
endmodule

module multi_digit_seconds_counter #(
    parameter int MAX_COUNT = 16000000,
    parameter int DIGITS    = 4,
    parameter int MUX_COUNT = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              clear,
    input  logic              up_down,
    output logic [6:0]        segments,
    output logic [DIGITS-1:0] digit_sel,
    output logic              wrap
);
    localparam int PW = (MAX_COUNT > 0) ? $clog2(MAX_COUNT + 1) : 1;
    localparam int SW = (MUX_COUNT > 0) ? $clog2(MUX_COUNT + 1) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [PW-1:0]            pre;
    logic                     tick;
    logic [DIGITS:0]          carry;
    logic [DIGITS-1:0][3:0]   digits;
    logic [SW-1:0]            scnt;
    logic [IW-1:0]            sidx;
    logic [3:0]               cur_digit;
    logic [6:0]               cur_seg;
    logic                     blank;

    assign tick     = run && (pre == PW'(MAX_COUNT));
    assign carry[0] = tick;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     pre <= '0;
        else if (clear) pre <= '0;
        else if (run)   pre <= tick ? '0 : pre + PW'(1);
    end

    genvar i;
    generate
        for (i = 0; i < DIGITS; i++) begin : g_digit
            msc_digit u_digit (
                .clk   (clk),
                .reset (reset),
                .clear (clear),
                .cin   (carry[i]),
                .up    (up_down),
                .value (digits[i]),
                .cout  (carry[i+1])
            );
        end
    endgenerate

    // Scan runs free of run/clear so the display never stalls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scnt <= '0;
            sidx <= '0;
        end else if (scnt == SW'(MUX_COUNT)) begin
            scnt <= '0;
            sidx <= (sidx == IW'(DIGITS - 1)) ? '0 : sidx + IW'(1);
        end else begin
            scnt <= scnt + SW'(1);
        end
    end

    assign cur_digit = digits[sidx];

    seg7 u_seg7 (
        .bcd (cur_digit),
        .seg (cur_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    // lz[k]: digit k and every more-significant digit are zero.
    logic [DIGITS-1:0] lz;
    assign lz[DIGITS-1] = (digits[DIGITS-1] == 4'd0);
    generate
        for (i = 0; i < DIGITS - 1; i++) begin : g_lz
            assign lz[i] = lz[i+1] && (digits[i] == 4'd0);
        end
    endgenerate
    assign blank = (sidx != '0) && lz[sidx];
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            segments  <= 7'h00;
            digit_sel <= '0;
            wrap      <= 1'b0;
        end else begin
            segments  <= blank ? 7'h00 : cur_seg;
            digit_sel <= DIGITS'(1) << sidx;
            wrap      <= carry[DIGITS] && !clear;
        end
    end
endmodule

// File: doc/multi_digit_seconds_counter.md
Name: multi_digit_seconds_counter

Overview:
- Parametrised successor to the single-digit seconds display.
- Prescales `clk` to a one-second tick and drives a DIGITS-wide BCD up/down counter with carry/borrow chaining.
- Time-multiplexes the digits onto one shared 7-segment bus with one-hot digit enables.
- Sits between the top-level io_in/io_out wrapper and the existing seg7 decoder, which it instantiates once.

Parameters:
- MAX_COUNT, 16000000, prescaler terminal value; tick period = MAX_COUNT+1 clk cycles; must be >= 1.
- DIGITS, 4, number of BCD digits; legal range 1..4.
- MUX_COUNT, 1023, scan divider terminal value; each digit is displayed for MUX_COUNT+1 cycles; must be >= 0.

Ports:
- clk, input, 1, single clock for all logic.
- reset, input, 1, asynchronous active-low reset (0 = reset).
- run, input, 1, 1 = prescaler advances; 0 = prescaler and digits hold.
- clear, input, 1, synchronous clear of prescaler and digits.
- up_down, input, 1, 1 = count up; 0 = count down.
- segments, output, 7, registered segment pattern, active high; bit0 = a ... bit6 = g (seg7 encoding).
- digit_sel, output, DIGITS, registered one-hot digit enable, active high; bit0 = least-significant digit.
- wrap, output, 1, registered one-cycle pulse on full-range wrap.

Behaviour:
- Reset (reset=0, asynchronous):
  - prescaler, all digits, scan counter and scan index go to 0.
  - segments=0, digit_sel=0, wrap=0.
  - State holds while reset is low.
- Prescaler:
  - Width is $clog2(MAX_COUNT+1).
  - When run=1: if prescaler==MAX_COUNT, it goes to 0 and tick=1 for that cycle; otherwise it increments.
  - When run=0: prescaler holds and tick=0.
- Clear:
  - clear=1 sets prescaler and all digits to 0 on the next edge.
  - Clear has priority over a tick in the same cycle (no count, no wrap).
  - Clear does not affect the scan counter or scan index.
- Count on tick, up (up_down=1):
  - digit0 increments. A digit at 9 goes to 0 and carries into the next digit. The carry ripples combinationally within the same edge.
  - All digits 9 -> all digits 0, and wrap=1 on the following cycle only.
- Count on tick, down (up_down=0):
  - digit0 decrements. A digit at 0 goes to 9 and borrows from the next digit.
  - All digits 0 -> all digits 9, and wrap=1.
- up_down is sampled only in the tick cycle. Changing it between ticks has no other effect.
- Digit values never leave 0..9.
- Scan:
  - Scan counter runs 0..MUX_COUNT continuously, independent of run and clear.
  - At terminal count it returns to 0 and the scan index advances. Index DIGITS-1 wraps to 0.
  - With DIGITS=1 the index stays at 0.
- Outputs:
  - Registered every cycle from the current scan index and digit values.
  - digit_sel = one-hot(index); segments = seg7(digit[index]).
  - Latency from a digit or index change to the outputs is 1 cycle.
  - segments and digit_sel always update on the same edge, so no cross-digit glitch.
  - First cycle after reset release: digit_sel=...0001, segments=7'h3F ("0").
- Reset mid-count or mid-scan: immediate return to reset values; counting restarts from 0 with a full MAX_COUNT+1 period.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - While digit[index] is a zero with all more-significant digits also zero, segments=0 for that slot. digit_sel still asserts.
  - digit0 is never blanked, so value 0 shows a single "0".
- Undefined: all digits are always shown, including leading zeros.
- Blank decision uses the same registered path, so latency is unchanged.

Test Plan:
- Bench parameters: MAX_COUNT=3, DIGITS=2, MUX_COUNT=1.
- Reset and scan: release reset with run=0 -> digit_sel cycles 01,01,10,10,01... from the first cycle; segments=7'h3F in both slots; no counting.
- Up count with carry: run=1, up_down=1 for 40 cycles (10 ticks) -> digits read 1,0 (display "10"); the digit1 slot shows 7'h06; wrap stays 0.
- Up wrap: preload to "99" via 396 running cycles, then 4 more cycles -> digits 0,0 and wrap high for exactly one cycle.
- Down borrow and wrap: from "00" with up_down=0, 4 cycles -> "99" and a wrap pulse; 4 more cycles -> "98".
- Clear vs tick and run hold: assert clear in a tick cycle -> "00" and no wrap. Drop run at prescaler=2 for 10 cycles, then restore -> the next tick comes exactly 2 cycles later.
- Async reset mid-operation, plus LEADING_ZERO_BLANK_EN build:
  - Pulse reset low between edges at "57" -> outputs are 0 immediately.
  - With the macro defined, value "05" -> digit1 slot segments=0, digit0 slot segments=7'h6D.
